// File: rtl/decodificador_teclado.sv
// 4x4 keypad scanner/debouncer feeding a 20-digit packet to operacional.
// Optional macro TECLADO_TIMEOUT_EN adds the inactivity auto-clear of the buffer.
package decodificador_teclado_pkg;
    localparam int unsigned NUM_DIGITOS = 20;

    typedef struct packed {
        logic [NUM_DIGITOS-1:0][3:0] digits;
    } senhaPac_t;
endpackage

module decodificador_teclado
    import decodificador_teclado_pkg::*;
#(
    parameter int unsigned SCAN_CICLOS     = 4,
    parameter int unsigned DEBOUNCE_CICLOS = 20
`ifdef TECLADO_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CICLOS = 5000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       teclado_en,
    input  logic [3:0] lin_i,
    output logic [3:0] col_o,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    localparam int unsigned SCAN_W = $clog2(SCAN_CICLOS + 1);
    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CICLOS + 1);

    typedef enum logic [1:0] {VARRE, DEBOUNCE, ACEITA, ESPERA_SOLTAR} estado_t;

    estado_t           estado, estado_nx;
    logic [DEB_W-1:0]  cnt, cnt_nx;
    logic [SCAN_W-1:0] scan_cnt, scan_nx;
    logic [1:0]        col_idx, col_idx_nx;
    logic [3:0]        lin_lat, lin_lat_nx;
    logic [3:0]        lin_m, lin_s;
    logic [3:0]        col_nx;
    logic [NUM_DIGITOS-1:0][3:0] digits_nx, base;
    logic              valid_nx, limpa_prox, limpa_nx;
    logic [1:0]        linha;
    logic              uma_linha, tecla_valida;
    logic [3:0]        tecla;

`ifdef TECLADO_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CICLOS + 1);
    logic [TMO_W-1:0]  tmo_cnt, tmo_nx;
    logic              tmo_hit;
    assign tmo_hit = (digitos_value.digits != '1) && (tmo_cnt == TMO_W'(TIMEOUT_CICLOS - 1));
`endif

    // Rows are asynchronous pins: two-flop synchronizer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lin_m <= 4'hF;
            lin_s <= 4'hF;
        end else begin
            lin_m <= lin_i;
            lin_s <= lin_m;
        end
    end

    // Key code from latched row pattern and the frozen column
    always_comb begin
        uma_linha = 1'b1;
        linha     = 2'd0;
        tecla     = 4'hF;
        case (lin_lat)
            4'b1110: linha = 2'd0;
            4'b1101: linha = 2'd1;
            4'b1011: linha = 2'd2;
            4'b0111: linha = 2'd3;
            default: uma_linha = 1'b0;
        endcase
        if (linha == 2'd3) begin
            case (col_idx)
                2'd0:    tecla = 4'hA;
                2'd1:    tecla = 4'h0;
                2'd2:    tecla = 4'hB;
                default: tecla = 4'hF;
            endcase
        end else begin
            tecla = 4'd3 * {2'b00, linha} + {2'b00, col_idx} + 4'd1;
        end
    end

    assign tecla_valida = uma_linha && (col_idx != 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado        <= VARRE;
            cnt           <= '0;
            scan_cnt      <= '0;
            col_idx       <= 2'd0;
            lin_lat       <= 4'hF;
            col_o         <= 4'b1110;
            digitos_value <= '1;
            digitos_valid <= 1'b0;
            limpa_prox    <= 1'b0;
`ifdef TECLADO_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
        end else begin
            estado        <= estado_nx;
            cnt           <= cnt_nx;
            scan_cnt      <= scan_nx;
            col_idx       <= col_idx_nx;
            lin_lat       <= lin_lat_nx;
            col_o         <= col_nx;
            digitos_value.digits <= digits_nx;
            digitos_valid <= valid_nx;
            limpa_prox    <= limpa_nx;
`ifdef TECLADO_TIMEOUT_EN
            tmo_cnt       <= tmo_nx;
`endif
        end
    end

    // Next state, scan position and debounce counter
    always_comb begin
        estado_nx  = estado;
        cnt_nx     = cnt;
        scan_nx    = scan_cnt;
        col_idx_nx = col_idx;
        lin_lat_nx = lin_lat;
        if (!teclado_en) begin
            estado_nx  = VARRE;
            cnt_nx     = '0;
            scan_nx    = '0;
            col_idx_nx = 2'd0;
        end else begin
            case (estado)
                VARRE: begin
                    if (lin_s != 4'hF) begin
                        estado_nx  = DEBOUNCE;
                        lin_lat_nx = lin_s;
                        cnt_nx     = '0;
                    end else if (scan_cnt == SCAN_W'(SCAN_CICLOS - 1)) begin
                        scan_nx    = '0;
                        col_idx_nx = col_idx + 2'd1;
                    end else begin
                        scan_nx = scan_cnt + SCAN_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (lin_s != lin_lat) begin
                        estado_nx  = VARRE;
                        cnt_nx     = '0;
                        scan_nx    = '0;
                        col_idx_nx = 2'd0;
                    end else if (cnt == DEB_W'(DEBOUNCE_CICLOS - 1)) begin
                        cnt_nx    = '0;
                        estado_nx = tecla_valida ? ACEITA : ESPERA_SOLTAR;
                    end else begin
                        cnt_nx = cnt + DEB_W'(1);
                    end
                end
                ACEITA: begin
                    estado_nx = ESPERA_SOLTAR;
                    cnt_nx    = '0;
                end
                ESPERA_SOLTAR: begin
                    if (lin_s != 4'hF) begin
                        cnt_nx = '0;
                    end else if (cnt == DEB_W'(DEBOUNCE_CICLOS - 1)) begin
                        estado_nx  = VARRE;
                        cnt_nx     = '0;
                        scan_nx    = '0;
                        col_idx_nx = 2'd0;
                    end else begin
                        cnt_nx = cnt + DEB_W'(1);
                    end
                end
                default: estado_nx = VARRE;
            endcase
        end
    end

    // Column drive, digit buffer, strobe and clear-on-next flag
    always_comb begin
        col_nx    = teclado_en ? ~(4'b0001 << col_idx_nx) : 4'hF;
        digits_nx = digitos_value.digits;
        base      = digitos_value.digits;
        valid_nx  = 1'b0;
        limpa_nx  = limpa_prox;
`ifdef TECLADO_TIMEOUT_EN
        tmo_nx    = tmo_cnt;
`endif
        if (!teclado_en) begin
            digits_nx = '1;
            limpa_nx  = 1'b0;
`ifdef TECLADO_TIMEOUT_EN
            tmo_nx    = '0;
`endif
        end else if (estado == ACEITA) begin
            base = limpa_prox ? '1 : digitos_value.digits;
`ifdef TECLADO_TIMEOUT_EN
            if (tmo_hit) base = '1;
            tmo_nx = '0;
`endif
            digits_nx = {base[NUM_DIGITOS-2:0], tecla};
            valid_nx  = 1'b1;
            limpa_nx  = (tecla == 4'hA) || (tecla == 4'hB);
        end
`ifdef TECLADO_TIMEOUT_EN
        else if (tmo_hit) begin
            digits_nx = '1;
            limpa_nx  = 1'b0;
            tmo_nx    = '0;
        end else if (digitos_value.digits != '1) begin
            tmo_nx = tmo_cnt + TMO_W'(1);
        end else begin
            tmo_nx = '0;
        end
`endif
    end

endmodule

// File: tb/tb_decodificador_teclado.sv
// Bench for decodificador_teclado: keypad matrix model plus a digit-queue reference.
module tb_decodificador_teclado;
    import decodificador_teclado_pkg::*;

    localparam int DEB = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       teclado_en;
    logic [3:0] lin_i;
    logic [3:0] col_o;
    senhaPac_t  digitos_value;
    logic       digitos_valid;

    always #5 clk = ~clk;

    decodificador_teclado dut (
        .clk(clk), .rst(rst), .teclado_en(teclado_en), .lin_i(lin_i),
        .col_o(col_o), .digitos_value(digitos_value), .digitos_valid(digitos_valid)
    );

    // Keypad: a held key pulls its row low while its column is driven low
    logic [1:0] key_r[2];
    logic [1:0] key_c[2];
    logic       key_on[2];
    always_comb begin
        lin_i = 4'hF;
        for (int k = 0; k < 2; k++)
            if (key_on[k] && col_o[key_c[k]] == 1'b0) lin_i[key_r[k]] = 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_strobe = 0, strobe_cyc = 0, t_low = 0;
    logic [3:0] lin_prev = 4'hF;
    always @(negedge clk) begin
        if (digitos_valid === 1'b1) begin
            n_strobe   <= n_strobe + 1;
            strobe_cyc <= cyc;
        end
        if (lin_i != 4'hF && lin_prev == 4'hF) t_low <= cyc;
        lin_prev <= lin_i;
    end

    int n_vec = 0, n_err = 0;
    int mq[$];
    bit mlimpa = 1'b0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Reference: newest digit first, cleared before the key following '*'/'#'
    task automatic mdl_accept(input logic [3:0] k);
        if (mlimpa) mq.delete();
        mq.push_front(int'(k));
        if (mq.size() > 20) void'(mq.pop_back());
        mlimpa = (k == 4'hA) || (k == 4'hB);
    endtask

    task automatic mdl_clear();
        mq.delete();
        mlimpa = 1'b0;
    endtask

    function automatic logic [79:0] esperado();
        logic [79:0] v;
        v = '1;
        for (int i = 0; i < mq.size() && i < 20; i++) v[4*i +: 4] = 4'(mq[i]);
        return v;
    endfunction

    task automatic pos(input logic [3:0] code, output logic [1:0] r, output logic [1:0] c);
        case (code)
            4'h0: begin r = 2'd3; c = 2'd1; end
            4'hA: begin r = 2'd3; c = 2'd0; end
            4'hB: begin r = 2'd3; c = 2'd2; end
            4'hD: begin r = 2'd3; c = 2'd3; end
            default: begin
                r = 2'((code - 4'd1) / 4'd3);
                c = 2'((code - 4'd1) % 4'd3);
            end
        endcase
    endtask

    task automatic wait_strobe(input int s0);
        for (int i = 0; i < 400 && n_strobe == s0; i++) tick(1);
    endtask

    task automatic wait_low_run(input string tag);
        int run;
        run = 0;
        for (int i = 0; i < 300 && run < 10; i++) begin
            tick(1);
            run = (lin_i != 4'hF) ? run + 1 : 0;
        end
        chk({tag, "_held"}, 80'(run), 80'd10);
    endtask

    // Press a key, expect one strobe at the nominal latency, release
    task automatic hit(input logic [3:0] code, input int hold, input string tag);
        int s0;
        logic [1:0] r, c;
        pos(code, r, c);
        s0 = n_strobe;
        key_r[0] = r; key_c[0] = c; key_on[0] = 1'b1;
        wait_strobe(s0);
        chk({tag, "_strobe"}, 80'(n_strobe - s0), 80'd1);
        mdl_accept(code);
        chk({tag, "_lat"}, 80'(strobe_cyc - t_low), 80'd24);
        chk({tag, "_val"}, digitos_value, esperado());
        tick(hold);
        key_on[0] = 1'b0;
        tick(2 * DEB + 20);
        chk({tag, "_once"}, 80'(n_strobe - s0), 80'd1);
    endtask

    initial begin
        int s0;
        logic [3:0] k;
        key_on[0] = 1'b0; key_on[1] = 1'b0;
        key_r[0] = 2'd0; key_r[1] = 2'd0; key_c[0] = 2'd0; key_c[1] = 2'd0;
        rst = 1'b0;
        teclado_en = 1'b1;
        tick(3);
        chk("rst_col", 80'(col_o), 80'(4'b1110));
        chk("rst_val", digitos_value, '1);
        chk("rst_valid", 80'(digitos_valid), 80'd0);
        rst = 1'b1;
        tick(5);

        hit(4'h5, 76, "k5");

        hit(4'h1, 10, "k1");
        hit(4'h2, 30, "k2");
        hit(4'h3, 5, "k3");
        hit(4'hA, 20, "kstar");
        chk("seq_123A", 80'(digitos_value.digits[3:0]), 80'h123A);
        hit(4'h7, 15, "k7");
        chk("after_star", digitos_value, {{19{4'hF}}, 4'h7});

        // Bouncing contact on key 8
        s0 = n_strobe;
        key_r[0] = 2'd2; key_c[0] = 2'd1;
        for (int i = 0; i < 12; i++) begin
            key_on[0] = ~key_on[0];
            tick(5);
        end
        chk("bounce_quiet", 80'(n_strobe - s0), 80'd0);
        key_on[0] = 1'b1;
        wait_strobe(s0);
        chk("bounce_strobe", 80'(n_strobe - s0), 80'd1);
        mdl_accept(4'h8);
        chk("bounce_lat", 80'(strobe_cyc - t_low), 80'd24);
        chk("bounce_val", digitos_value, esperado());
        tick(30);
        key_on[0] = 1'b0;
        tick(2 * DEB + 20);
        chk("bounce_once", 80'(n_strobe - s0), 80'd1);

        // Letter key and two rows in one column: debounced, never accepted
        s0 = n_strobe;
        key_r[0] = 2'd3; key_c[0] = 2'd3; key_on[0] = 1'b1;
        tick(100);
        key_on[0] = 1'b0;
        tick(60);
        chk("letter_none", 80'(n_strobe - s0), 80'd0);
        chk("letter_val", digitos_value, esperado());
        key_r[0] = 2'd0; key_c[0] = 2'd0; key_on[0] = 1'b1;
        key_r[1] = 2'd1; key_c[1] = 2'd0; key_on[1] = 1'b1;
        tick(100);
        key_on[0] = 1'b0; key_on[1] = 1'b0;
        tick(60);
        chk("multi_none", 80'(n_strobe - s0), 80'd0);
        chk("multi_val", digitos_value, esperado());

        // Enable dropped while key 2 is being debounced
        s0 = n_strobe;
        key_r[0] = 2'd0; key_c[0] = 2'd1; key_on[0] = 1'b1;
        wait_low_run("en");
        teclado_en = 1'b0;
        mdl_clear();
        tick(5);
        chk("dis_col", 80'(col_o), 80'hF);
        chk("dis_val", digitos_value, '1);
        tick(20);
        chk("dis_none", 80'(n_strobe - s0), 80'd0);
        teclado_en = 1'b1;
        wait_strobe(s0);
        chk("reen_strobe", 80'(n_strobe - s0), 80'd1);
        mdl_accept(4'h2);
        chk("reen_lat", 80'(strobe_cyc - t_low), 80'd24);
        chk("reen_val", digitos_value, esperado());
        key_on[0] = 1'b0;
        tick(2 * DEB + 20);

        // Random keys 0-9, '*', '#'
        for (int i = 0; i < 10; i++) begin
            k = 4'($urandom_range(0, 11));
            hit(k, int'($urandom_range(0, 80)), $sformatf("rnd%0d_%0h", i, k));
        end

        // Reset in the middle of a debounce
        s0 = n_strobe;
        k = 4'($urandom_range(0, 9));
        pos(k, key_r[0], key_c[0]);
        key_on[0] = 1'b1;
        wait_low_run("rst");
        rst = 1'b0;
        #1;
        mdl_clear();
        chk("mid_rst_col", 80'(col_o), 80'(4'b1110));
        chk("mid_rst_val", digitos_value, '1);
        chk("mid_rst_valid", 80'(digitos_valid), 80'd0);
        tick(3);
        key_on[0] = 1'b0;
        rst = 1'b1;
        tick(60);
        chk("mid_rst_none", 80'(n_strobe - s0), 80'd0);

        // Inactivity after key 9
        hit(4'h9, 10, "k9");
        s0 = n_strobe;
`ifdef TECLADO_TIMEOUT_EN
        tick(5100);
        mdl_clear();
        chk("tmo_val", digitos_value, esperado());
        chk("tmo_none", 80'(n_strobe - s0), 80'd0);
`else
        tick(6000);
        chk("keep_val", digitos_value, esperado());
        chk("keep_none", 80'(n_strobe - s0), 80'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decodificador_teclado.md
# decodificador_teclado

Scans a 4x4 matrix keypad, debounces key presses and delivers digits to `operacional` over the `digitos_value`/`digitos_valid` interface: a 20-digit shift buffer plus a one-cycle strobe per accepted key. It sits between the keypad pins and `operacional`, and is gated by `operacional`'s `teclado_en`. Clearing the buffer after `*`/`#` and on inactivity is done here, so `operacional` always sees a fresh packet per password attempt.

## Interface
- `SCAN_CICLOS`, 4: cycles each column stays driven while scanning.
- `DEBOUNCE_CICLOS`, 20: consecutive stable cycles required for press and for release.
- `TIMEOUT_CICLOS`, 5000: inactivity cycles before buffer auto-clear (5 s at `UM_SEGUNDO`=1000).
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `teclado_en`  in  1  keypad enable from `operacional`.
- `lin_i`  in  4  keypad rows, active-low, asynchronous (pulled up).
- `col_o`  out  4  keypad column drive, one-hot low; 4'b1111 = idle.
- `digitos_value`  out  80  `senhaPac_t`; `.digits[19:0]` of 4 bits; `digits[0]` is the newest; 4'hF means empty.
- `digitos_valid`  out  1  one-cycle strobe, coincident with the updated `digitos_value`.

## Operation
- `lin_i` passes through a 2-FF synchronizer (`lin_s`). All decisions below use `lin_s`.
- Key map, as [row][col]:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
  - Digits 0-9 map to 4'h0-4'h9, `*` to 4'hA, `#` to 4'hB.
  - Letter keys A-D are ignored: they are debounced but produce no strobe.
- FSM states: VARRE, DEBOUNCE, ACEITA, ESPERA_SOLTAR.
- VARRE:
  - `col_o` rotates 1110→1101→1011→0111→1110, changing every `SCAN_CICLOS` cycles.
  - If `lin_s` is not 4'hF, latch the column and `lin_s`, freeze `col_o`, and go to DEBOUNCE.
- DEBOUNCE:
  - The counter increments each cycle that `lin_s` equals the latched pattern.
  - Any mismatch returns to VARRE, with the scan restarting at column 0.
  - When the count reaches `DEBOUNCE_CICLOS`:
    - Exactly one row low and a digit/`*`/`#` key: go to ACEITA.
    - Multiple rows low, or a letter key: go to ESPERA_SOLTAR with no strobe.
- ACEITA (one cycle):
  - `digitos_value.digits <= {digits[18:0], key}`, and `digitos_valid` = 1.
  - If `limpa_prox` is set, the base is all-F instead, giving `{19×4'hF, key}`.
  - `limpa_prox` is set when the key is 4'hA or 4'hB, otherwise cleared.
  - Next state: ESPERA_SOLTAR.
- ESPERA_SOLTAR:
  - Wait for `lin_s` == 4'hF for `DEBOUNCE_CICLOS` consecutive cycles; any low row restarts the count.
  - Then go to VARRE, column 0.
- `teclado_en` = 0:
  - FSM forced to VARRE with counters cleared.
  - `col_o` = 4'b1111, no strobes.
  - `digitos_value` = all 1s, `limpa_prox` = 0.
  - Deassertion mid-DEBOUNCE aborts the press.
  - On re-enable, scanning starts at column 0. A key still held is accepted after a full debounce.
- Holding a key produces exactly one strobe; auto-repeat is not supported.

## Timing
- Reset values:
  - `col_o` = 4'b1110.
  - `digitos_value` = all 1s.
  - `digitos_valid` = 0.
  - FSM = VARRE, `limpa_prox` = 0, all counters 0.
- Press latency, from a stable `lin_i` low on the driven column to `digitos_valid`: 2 (sync) + 1 (detect) + `DEBOUNCE_CICLOS` + 1 cycles. That is 24 cycles at the defaults.
- Minimum spacing between two strobes: 2×`DEBOUNCE_CICLOS` + 4 cycles.
- A reset asserted mid-operation clears everything immediately; there is no pending strobe after release.

## Configuration
- `TECLADO_TIMEOUT_EN` defined:
  - A counter runs while `digitos_value` is not all 1s and resets on each ACEITA.
  - At `TIMEOUT_CICLOS` it sets `digitos_value` to all 1s and `limpa_prox` to 0, with no strobe.
  - If the timeout and ACEITA fall in the same cycle, ACEITA wins. Its shift uses the all-F base.
- `TECLADO_TIMEOUT_EN` undefined: there is no timeout counter, and the buffer persists until `*`/`#`+next key, `teclado_en` = 0, or reset.

## Test plan
- Reset, enable, press key "5" (row 1 low while `col_o` = 1101), held 100 cycles:
  - Exactly one strobe, 24 cycles after the stable press.
  - `digits[0]` = 4'h5, `digits[19:1]` all F.
- Keys 1,2,3 then `*`:
  - Strobe 4 shows `digits[3:0]` = {1,2,3,A}.
  - Next key "7" gives `{19×F, 7}`.
- Bounce: row toggles every 5 cycles for 60 cycles, then stable low → exactly one strobe, none during bouncing.
- Letter key "D", and two rows low together → no strobe; `digitos_value` unchanged.
- `teclado_en` dropped mid-DEBOUNCE:
  - No strobe, `col_o` = 4'b1111, value all 1s.
  - Re-enable with the key held → one strobe after a full debounce.
- With `TECLADO_TIMEOUT_EN`: key "9" then 5000 idle cycles → `digitos_value` all 1s, `digitos_valid` stays 0. Without the macro, the value is still `{19×F, 9}` at 6000 cycles.
